// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: the master drives controls, the slave
// returns the count and flags.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat_mode;
  logic [WIDTH-1:0] counter_out;
  logic             tc;
  logic             wrap_o;
  logic             ovf_sticky;

  modport master (
    output en, up_dn, clr, load, load_val, sat_mode,
    input  counter_out, tc, wrap_o, ovf_sticky
  );

  modport slave (
    input  en, up_dn, clr, load, load_val, sat_mode,
    output counter_out, tc, wrap_o, ovf_sticky
  );
endinterface

// File: rtl/mod_counter.sv
// Prescaled up/down modulo counter with wrap or saturate at the 0/MAX_VAL boundaries,
// one-cycle wrap pulse and sticky boundary flag.
module mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE = 1
) (
  input logic         clk,
  input logic         rst_n,
  mod_counter_if.slave bus
);

  localparam int unsigned     PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PLast  = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;

  // at_bound doubles as tc: it is the boundary in the currently selected direction
  assign at_bound = bus.up_dn ? (cnt_q == MaxVal) : (cnt_q == '0);
  assign step     = bus.en && (pcnt_q == PLast);

  always_comb begin
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.clr) begin
      cnt_d  = '0;
      pcnt_d = '0;
      ovf_d  = 1'b0;
    end else if (bus.load) begin
      cnt_d  = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
      pcnt_d = '0;
    end else if (bus.en) begin
      pcnt_d = step ? '0 : pcnt_q + 1'b1;
      if (step) begin
        if (at_bound) begin
          ovf_d = 1'b1;
          if (!bus.sat_mode) begin
            cnt_d  = bus.up_dn ? '0 : MaxVal;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = bus.up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.counter_out = cnt_q;
  assign bus.tc          = at_bound;
  assign bus.wrap_o      = wrap_q;
  assign bus.ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed scoreboard bench for mod_counter: one instance with PRESCALE=1, one with
// PRESCALE=3, both MAX_VAL=9.
module tb_mod_counter;

  typedef struct {
    logic [3:0] cnt;
    logic       wrap;
    logic       ovf;
    logic       tc;
    int         id;
  } exp_t;

  logic clk;
  logic rst1_n;
  logic rst3_n;
  int   n_chk;
  int   n_fail;
  int   id1;
  int   id3;
  exp_t q1[$];
  exp_t q3[$];

  mod_counter_if #(.WIDTH(4)) b1 ();
  mod_counter_if #(.WIDTH(4)) b3 ();

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (b1)
  );

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input exp_t e, input logic [3:0] c, input logic w,
                       input logic o, input logic t);
    n_chk++;
    if (c !== e.cnt || w !== e.wrap || o !== e.ovf || t !== e.tc) begin
      n_fail++;
      $display("FAIL %s #%0d: got cnt=%0d wrap=%b ovf=%b tc=%b, want cnt=%0d wrap=%b ovf=%b tc=%b",
               nm, e.id, c, w, o, t, e.cnt, e.wrap, e.ovf, e.tc);
    end
  endtask

  // Monitors: an entry queued before this edge is due now; sample 1 time unit later
  always @(posedge clk) begin
    bit   due;
    exp_t e;
    due = (q1.size() > 0);
    #1;
    if (due) begin
      e = q1.pop_front();
      check("dut1", e, b1.counter_out, b1.wrap_o, b1.ovf_sticky, b1.tc);
    end
  end

  always @(posedge clk) begin
    bit   due;
    exp_t e;
    due = (q3.size() > 0);
    #1;
    if (due) begin
      e = q3.pop_front();
      check("dut3", e, b3.counter_out, b3.wrap_o, b3.ovf_sticky, b3.tc);
    end
  end

  task automatic s1(input logic rst, input logic en, input logic up, input logic clr,
                    input logic ld, input logic [3:0] lv, input logic sat,
                    input logic [3:0] ec, input logic ew, input logic eo, input logic et);
    exp_t e;
    @(negedge clk);
    rst1_n = rst; b1.en = en; b1.up_dn = up; b1.clr = clr;
    b1.load = ld; b1.load_val = lv; b1.sat_mode = sat;
    e = '{cnt: ec, wrap: ew, ovf: eo, tc: et, id: id1};
    q1.push_back(e);
    id1++;
  endtask

  task automatic s3(input logic rst, input logic en, input logic up, input logic clr,
                    input logic ld, input logic [3:0] lv, input logic sat,
                    input logic [3:0] ec, input logic ew, input logic eo, input logic et);
    exp_t e;
    @(negedge clk);
    rst3_n = rst; b3.en = en; b3.up_dn = up; b3.clr = clr;
    b3.load = ld; b3.load_val = lv; b3.sat_mode = sat;
    e = '{cnt: ec, wrap: ew, ovf: eo, tc: et, id: id3};
    q3.push_back(e);
    id3++;
  endtask

  int a_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int e_cnt[11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
  bit e_en[11]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    n_chk = 0; n_fail = 0; id1 = 0; id3 = 0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    b1.en = 0; b1.up_dn = 1; b1.clr = 0; b1.load = 0; b1.load_val = '0; b1.sat_mode = 0;
    b3.en = 0; b3.up_dn = 1; b3.clr = 0; b3.load = 0; b3.load_val = '0; b3.sat_mode = 0;

    // Reset overrides enable
    //  rst en up clr ld lv  sat   cnt wrap ovf tc
    s1(0, 1, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    // a) count up through the wrap
    for (int i = 0; i < 12; i++)
      s1(1, 1, 1, 0, 0, 4'd0, 0, 4'(a_cnt[i]), i == 9, i >= 9, a_cnt[i] == 9);
    // b) clear, then saturating down steps at 0
    s1(1, 1, 0, 1, 0, 4'd0, 1,  4'd0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      s1(1, 1, 0, 0, 0, 4'd0, 1, 4'd0, 0, 1, 1);
    // c) load clamps to MAX_VAL; load beats a same-edge step
    s1(1, 0, 1, 0, 1, 4'd13, 1, 4'd9, 0, 1, 1);
    s1(1, 1, 1, 0, 1, 4'd5, 0,  4'd5, 0, 1, 0);
    s1(1, 1, 1, 0, 0, 4'd0, 0,  4'd6, 0, 1, 0);
    s1(1, 1, 1, 0, 0, 4'd0, 0,  4'd7, 0, 1, 0);
    // d) clear beats load and drops the sticky flag
    s1(1, 1, 1, 1, 1, 4'd3, 0,  4'd0, 0, 0, 0);
    // down-wrap from 0, then saturating up at MAX_VAL
    s1(1, 1, 0, 0, 0, 4'd0, 0,  4'd9, 1, 1, 0);
    s1(1, 1, 1, 0, 0, 4'd0, 1,  4'd9, 0, 1, 1);
    s1(1, 0, 1, 0, 0, 4'd0, 1,  4'd9, 0, 1, 1);
    // f) reset mid-count, then resume from 0
    s1(1, 0, 1, 0, 1, 4'd6, 0,  4'd6, 0, 1, 0);
    s1(0, 1, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    s1(1, 1, 1, 0, 0, 4'd0, 0,  4'd1, 0, 0, 0);
    s1(1, 0, 1, 0, 0, 4'd0, 0,  4'd1, 0, 0, 0);

    // e) PRESCALE=3 with a two-edge enable gap
    s3(0, 1, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      s3(1, e_en[i], 1, 0, 0, 4'd0, 0, 4'(e_cnt[i]), 0, 0, 0);
    // load restarts the prescaler
    s3(1, 1, 1, 0, 1, 4'd0, 0,  4'd0, 0, 0, 0);
    s3(1, 1, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    s3(1, 1, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    s3(1, 1, 1, 0, 0, 4'd0, 0,  4'd1, 0, 0, 0);
    // direction change mid-prescale, then a prescaled down-wrap
    s3(1, 1, 0, 0, 0, 4'd0, 0,  4'd1, 0, 0, 0);
    s3(1, 1, 0, 0, 0, 4'd0, 0,  4'd1, 0, 0, 0);
    s3(1, 1, 0, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
    s3(1, 1, 0, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
    s3(1, 1, 0, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
    s3(1, 1, 0, 0, 0, 4'd0, 0,  4'd9, 1, 1, 0);
    s3(1, 0, 0, 0, 0, 4'd0, 0,  4'd9, 0, 1, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", q1.size(), q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
